// File: rtl/pmult_pkg.sv
// Shared types and configuration helpers for the pipelined shift-add multiplier.
package pmult_pkg;

    // Per-slot control carried down the pipeline beside the operand/accumulator data.
    typedef struct packed {
        logic valid;
        logic neg;
    } pmult_stage_ctl_t;

    function automatic int pmult_chunk(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic bit pmult_cfg_ok(input int width, input int stages);
        return (width >= 2) && (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/pmult_stage.sv
// One shift-add step: adds a * (CHUNK-bit digit of b) << SHIFT and registers the slot.
module pmult_stage
    import pmult_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4,
    parameter int CHUNK = 2,
    parameter int SHIFT = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_en,
    input  pmult_stage_ctl_t     i_ctl,
    input  logic [TAG_W-1:0]     i_tag,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    input  logic [2*WIDTH-1:0]   i_acc,
    output pmult_stage_ctl_t     o_ctl,
    output logic [TAG_W-1:0]     o_tag,
    output logic [WIDTH-1:0]     o_a,
    output logic [WIDTH-1:0]     o_b,
    output logic [2*WIDTH-1:0]   o_acc
);

    logic [CHUNK-1:0]   w_digit;
    logic [2*WIDTH-1:0] w_pp;

    assign w_digit = i_b[SHIFT +: CHUNK];
    assign w_pp    = ({{WIDTH{1'b0}}, i_a} * {{(2*WIDTH-CHUNK){1'b0}}, w_digit}) << SHIFT;

    // Slot register; holds everything while the pipeline is stalled.
    always_ff @(posedge clk) begin
        if (reset) begin
            o_ctl <= '0;
            o_tag <= '0;
            o_a   <= '0;
            o_b   <= '0;
            o_acc <= '0;
        end else if (i_en) begin
            o_ctl <= i_ctl;
            o_tag <= i_tag;
            o_a   <= i_a;
            o_b   <= i_b;
            o_acc <= i_acc + w_pp;
        end
    end

endmodule

// File: rtl/pipelined_mult_n.sv
// WIDTH x WIDTH pipelined multiplier with valid/ready backpressure and a sideband tag.
// Optional two's-complement mode is enabled by defining PMULT_SIGNED_EN.
module pipelined_mult_n
    import pmult_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 4,
    parameter int TAG_W  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [TAG_W-1:0]     in_tag,
`ifdef PMULT_SIGNED_EN
    input  logic                 in_signed,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic [TAG_W-1:0]     out_tag
);

    localparam int PMULT_CHUNK = pmult_chunk(WIDTH, STAGES);

    if (!pmult_cfg_ok(WIDTH, STAGES)) begin : g_bad_cfg
        $error("pipelined_mult_n: WIDTH must be >= 2 and divisible by STAGES, STAGES in 1..WIDTH");
    end

    pmult_stage_ctl_t   w_ctl [0:STAGES];
    logic [TAG_W-1:0]   w_tag [0:STAGES];
    logic [WIDTH-1:0]   w_a   [0:STAGES];
    logic [WIDTH-1:0]   w_b   [0:STAGES];
    logic [2*WIDTH-1:0] w_acc [0:STAGES];

    pmult_stage_ctl_t   w_ctl_in;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [2*WIDTH-1:0] w_result;
    logic               w_stall;
    logic               r_out_valid;
    logic [2*WIDTH-1:0] r_product;
    logic [TAG_W-1:0]   r_out_tag;

    assign w_stall  = r_out_valid && !out_ready;
    assign in_ready = !w_stall;

    // Input conditioning: magnitudes and result sign for signed operands.
    always_comb begin
        w_ctl_in.valid = in_valid;
        w_ctl_in.neg   = 1'b0;
        w_a_mag        = a;
        w_b_mag        = b;
`ifdef PMULT_SIGNED_EN
        if (in_signed) begin
            w_ctl_in.neg = a[WIDTH-1] ^ b[WIDTH-1];
            w_a_mag      = a[WIDTH-1] ? (~a + {{(WIDTH-1){1'b0}}, 1'b1}) : a;
            w_b_mag      = b[WIDTH-1] ? (~b + {{(WIDTH-1){1'b0}}, 1'b1}) : b;
        end else begin
            w_ctl_in.neg = 1'b0;
        end
`endif
    end

    assign w_ctl[0] = w_ctl_in;
    assign w_tag[0] = in_tag;
    assign w_a[0]   = w_a_mag;
    assign w_b[0]   = w_b_mag;
    assign w_acc[0] = '0;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        pmult_stage #(
            .WIDTH (WIDTH),
            .TAG_W (TAG_W),
            .CHUNK (PMULT_CHUNK),
            .SHIFT (k * PMULT_CHUNK)
        ) u_stage (
            .clk   (clk),
            .reset (reset),
            .i_en  (!w_stall),
            .i_ctl (w_ctl[k]),
            .i_tag (w_tag[k]),
            .i_a   (w_a[k]),
            .i_b   (w_b[k]),
            .i_acc (w_acc[k]),
            .o_ctl (w_ctl[k+1]),
            .o_tag (w_tag[k+1]),
            .o_a   (w_a[k+1]),
            .o_b   (w_b[k+1]),
            .o_acc (w_acc[k+1])
        );
    end

`ifdef PMULT_SIGNED_EN
    assign w_result = w_ctl[STAGES].neg ? (~w_acc[STAGES] + {{(2*WIDTH-1){1'b0}}, 1'b1})
                                        : w_acc[STAGES];
`else
    assign w_result = w_acc[STAGES];
`endif

    // Output register: product/tag/valid, held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_product   <= '0;
            r_out_tag   <= '0;
        end else if (!w_stall) begin
            r_out_valid <= w_ctl[STAGES].valid;
            r_product   <= w_result;
            r_out_tag   <= w_tag[STAGES];
        end
    end

    assign out_valid = r_out_valid;
    assign product   = r_product;
    assign out_tag   = r_out_tag;

endmodule

// File: tb/tb_pipelined_mult_n.sv
// Directed bench for pipelined_mult_n: a 4x4/4-stage and a 16x16/8-stage instance.
module tb_pipelined_mult_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        in_valid4, in_ready4, out_valid4, out_ready4;
    logic [3:0]  a4, b4, tag4, otag4;
    logic [7:0]  prod4;
    logic        in_valid16, in_ready16, out_valid16, out_ready16;
    logic [15:0] a16, b16;
    logic [3:0]  tag16, otag16;
    logic [31:0] prod16;
`ifdef PMULT_SIGNED_EN
    logic        sg4, sg16;
`endif

    pipelined_mult_n #(.WIDTH(4), .STAGES(4), .TAG_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .in_tag(tag4),
`ifdef PMULT_SIGNED_EN
        .in_signed(sg4),
`endif
        .out_valid(out_valid4), .out_ready(out_ready4), .product(prod4), .out_tag(otag4)
    );

    pipelined_mult_n #(.WIDTH(16), .STAGES(8), .TAG_W(4)) u_dut16 (
        .clk(clk), .reset(reset), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .in_tag(tag16),
`ifdef PMULT_SIGNED_EN
        .in_signed(sg16),
`endif
        .out_valid(out_valid16), .out_ready(out_ready16), .product(prod16), .out_tag(otag16)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  tag;
        logic        sgn;
        logic [31:0] exp;
    } vec_t;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out4(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            step();
            if (out_valid4 === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_out16(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            step();
            if (out_valid16 === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Back-to-back stream into the 4-bit instance; results must come out on consecutive cycles.
    task automatic run_stream4(input vec_t tv [8], input int n);
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    a4 = tv[i].a[3:0]; b4 = tv[i].b[3:0]; tag4 = tv[i].tag;
`ifdef PMULT_SIGNED_EN
                    sg4 = tv[i].sgn;
`endif
                    in_valid4 = 1'b1;
                    step();
                end
                in_valid4 = 1'b0;
            end
            begin
                bit ok;
                for (int i = 0; i < n; i++) begin
                    if (i == 0) begin
                        wait_out4(12, ok);
                        chk("stream4_first_seen", {31'd0, ok}, 32'd1);
                    end else begin
                        step();
                        chk("stream4_consecutive", {31'd0, out_valid4}, 32'd1);
                    end
                    chk("stream4_product", {24'd0, prod4}, tv[i].exp);
                    chk("stream4_tag", {28'd0, otag4}, {28'd0, tv[i].tag});
                end
            end
        join
    endtask

    task automatic run_stream16(input vec_t tv [8], input int n);
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    a16 = tv[i].a; b16 = tv[i].b; tag16 = tv[i].tag;
                    in_valid16 = 1'b1;
                    step();
                end
                in_valid16 = 1'b0;
            end
            begin
                bit ok;
                for (int i = 0; i < n; i++) begin
                    if (i == 0) begin
                        wait_out16(16, ok);
                        chk("stream16_first_seen", {31'd0, ok}, 32'd1);
                    end else begin
                        step();
                        chk("stream16_consecutive", {31'd0, out_valid16}, 32'd1);
                    end
                    chk("stream16_product", prod16, tv[i].exp);
                    chk("stream16_tag", {28'd0, otag16}, {28'd0, tv[i].tag});
                end
            end
        join
    endtask

    initial begin
        vec_t tbl4 [8];
        vec_t tbl16 [8];
        bit   ok;
        int   ghosts;

        tbl4[0] = '{16'd0,  16'd0,  4'h1, 1'b0, 32'd0};
        tbl4[1] = '{16'd15, 16'd15, 4'h2, 1'b0, 32'd225};
        tbl4[2] = '{16'd7,  16'd9,  4'h3, 1'b0, 32'd63};
        tbl4[3] = '{16'd1,  16'd1,  4'h4, 1'b0, 32'd1};
        tbl4[4] = '{16'd12, 16'd10, 4'h5, 1'b0, 32'd120};
        tbl4[5] = '{16'd15, 16'd1,  4'h6, 1'b0, 32'd15};
        tbl4[6] = '{16'd2,  16'd8,  4'h7, 1'b0, 32'd16};
        tbl4[7] = '{16'd13, 16'd5,  4'h8, 1'b0, 32'd65};

        tbl16[0] = '{16'h1234, 16'h0010, 4'h1, 1'b0, 32'h0001_2340};
        tbl16[1] = '{16'h8000, 16'h0002, 4'h2, 1'b0, 32'h0001_0000};
        tbl16[2] = '{16'h00FF, 16'h0101, 4'h3, 1'b0, 32'h0000_FFFF};
        tbl16[3] = '{16'hABCD, 16'h0001, 4'h4, 1'b0, 32'h0000_ABCD};
        tbl16[4] = '{16'hFFFF, 16'hFFFF, 4'h5, 1'b0, 32'hFFFE_0001};
        for (int i = 5; i < 8; i++) tbl16[i] = '{16'd0, 16'd0, 4'h0, 1'b0, 32'd0};

        reset = 1'b1;
        in_valid4 = 1'b0; a4 = 4'd0; b4 = 4'd0; tag4 = 4'd0; out_ready4 = 1'b1;
        in_valid16 = 1'b0; a16 = 16'd0; b16 = 16'd0; tag16 = 4'd0; out_ready16 = 1'b1;
`ifdef PMULT_SIGNED_EN
        sg4 = 1'b0; sg16 = 1'b0;
`endif
        step();
        step();
        chk("reset_out_valid", {31'd0, out_valid4}, 32'd0);
        chk("reset_product", {24'd0, prod4}, 32'd0);
        chk("reset_out_tag", {28'd0, otag4}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready4}, 32'd1);
        chk("reset_out_valid16", {31'd0, out_valid16}, 32'd0);
        reset = 1'b0;
        step();

        // Single pulse, exact latency of 4 cycles after the accept edge.
        a4 = 4'd3; b4 = 4'd5; tag4 = 4'h9; in_valid4 = 1'b1;
        step();
        in_valid4 = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            chk("latency4_early", {31'd0, out_valid4}, 32'd0);
            step();
        end
        chk("latency4_valid", {31'd0, out_valid4}, 32'd1);
        chk("latency4_product", {24'd0, prod4}, 32'd15);
        chk("latency4_tag", {28'd0, otag4}, 32'h9);
        step();
        chk("latency4_single", {31'd0, out_valid4}, 32'd0);

        run_stream4(tbl4, 8);
        step();
        chk("stream4_drained", {31'd0, out_valid4}, 32'd0);

`ifdef PMULT_SIGNED_EN
        begin
            vec_t stbl [8];
            stbl[0] = '{16'd13, 16'd5,  4'hA, 1'b1, 32'h0000_00F1};
            stbl[1] = '{16'd8,  16'd8,  4'hB, 1'b1, 32'h0000_0040};
            stbl[2] = '{16'd13, 16'd5,  4'hC, 1'b0, 32'd65};
            stbl[3] = '{16'd15, 16'd15, 4'hD, 1'b1, 32'h0000_0001};
            stbl[4] = '{16'd7,  16'd8,  4'hE, 1'b1, 32'h0000_00C8};
            stbl[5] = '{16'd8,  16'd7,  4'hF, 1'b0, 32'd56};
            stbl[6] = '{16'd0,  16'd9,  4'h1, 1'b1, 32'd0};
            stbl[7] = '{16'd9,  16'd9,  4'h2, 1'b0, 32'd81};
            run_stream4(stbl, 8);
            sg4 = 1'b0;
            step();
        end
`endif

        // Backpressure: hold out_ready low for 3 cycles once the first result shows.
        out_ready4 = 1'b0;
        a4 = 4'd2; b4 = 4'd3; tag4 = 4'h1; in_valid4 = 1'b1; step();
        a4 = 4'd4; b4 = 4'd4; tag4 = 4'h2; step();
        a4 = 4'd5; b4 = 4'd3; tag4 = 4'h3; step();
        in_valid4 = 1'b0;
        wait_out4(12, ok);
        chk("bp_first_seen", {31'd0, ok}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            chk("bp_in_ready_low", {31'd0, in_ready4}, 32'd0);
            chk("bp_product_hold", {24'd0, prod4}, 32'd6);
            chk("bp_tag_hold", {28'd0, otag4}, 32'h1);
            if (k < 2) step();
        end
        out_ready4 = 1'b1;
        wait_out4(4, ok);
        chk("bp_second_seen", {31'd0, ok}, 32'd1);
        chk("bp_second_product", {24'd0, prod4}, 32'd16);
        chk("bp_second_tag", {28'd0, otag4}, 32'h2);
        wait_out4(4, ok);
        chk("bp_third_seen", {31'd0, ok}, 32'd1);
        chk("bp_third_product", {24'd0, prod4}, 32'd15);
        chk("bp_third_tag", {28'd0, otag4}, 32'h3);
        ghosts = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (out_valid4 !== 1'b0) ghosts++;
        end
        chk("bp_no_duplicate", ghosts, 32'd0);

        // Reset with three transactions in flight; none may ever emerge.
        a4 = 4'd5; b4 = 4'd5; tag4 = 4'hC; in_valid4 = 1'b1; step();
        a4 = 4'd6; b4 = 4'd6; tag4 = 4'hD; step();
        a4 = 4'd7; b4 = 4'd7; tag4 = 4'hE; step();
        in_valid4 = 1'b0;
        reset = 1'b1;
        step();
        chk("midreset_out_valid", {31'd0, out_valid4}, 32'd0);
        chk("midreset_product", {24'd0, prod4}, 32'd0);
        chk("midreset_out_tag", {28'd0, otag4}, 32'd0);
        chk("midreset_in_ready", {31'd0, in_ready4}, 32'd1);
        reset = 1'b0;
        a4 = 4'd0; b4 = 4'd0;
        ghosts = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (out_valid4 !== 1'b0) ghosts++;
        end
        chk("midreset_discarded", ghosts, 32'd0);

        // Wide instance: 65535*65535 with 8-cycle latency, then a short stream.
        a16 = 16'hFFFF; b16 = 16'hFFFF; tag16 = 4'h7; in_valid16 = 1'b1;
        step();
        in_valid16 = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            chk("latency16_early", {31'd0, out_valid16}, 32'd0);
            step();
        end
        chk("latency16_valid", {31'd0, out_valid16}, 32'd1);
        chk("latency16_product", prod16, 32'hFFFE_0001);
        chk("latency16_tag", {28'd0, otag16}, 32'h7);
        step();
        run_stream16(tbl16, 5);
        step();
        chk("stream16_drained", {31'd0, out_valid16}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
